axi_read_arbiter: RTL and testbench
===================================

# axi_read_arbiter

Parametrised N-to-1 AXI3 read-channel arbiter that merges the AR/R channels of several cache masters (instruction cache, data cache, future uncached or prefetch ports) onto the single CPU AXI read port. It replaces the vendor crossbar on the read side with in-house RTL. It adds selectable fixed or round-robin arbitration, master-index ID tagging and burst-length checking. One burst is outstanding at a time, so R beats never interleave.

## Interface
Parameters:
- N_MASTERS, 2, number of upstream read masters (2..8)
- ID_W, 4, upstream ARID/RID width
- ADDR_W, 32, address width
- DATA_W, 32, data width
- ARB_MODE, 1, 0 = fixed priority (highest index wins), 1 = round-robin
- IDX_W, $clog2(N_MASTERS), derived, master-index width

Ports (upstream buses are flattened; master k occupies slice k):
- aclk  in  1  clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-high reset
- s_arid  in  N*ID_W  upstream ARID
- s_araddr  in  N*ADDR_W  upstream address
- s_arlen/s_arsize/s_arburst/s_arlock/s_arcache/s_arprot  in  N*4/N*3/N*2/N*2/N*4/N*3  upstream AR sideband
- s_arvalid  in  N  request valid
- s_arready  out  N  request accepted
- s_rid  out  N*ID_W  RID, low ID_W bits of m_rid
- s_rdata  out  N*DATA_W  read data, m_rdata broadcast to all slices
- s_rresp  out  N*2  read response, broadcast
- s_rlast  out  N  last beat, broadcast
- s_rvalid  out  N  beat valid, granted master only
- s_rready  in  N  beat ready
- m_arid  out  IDX_W+ID_W  {grant index, upstream id}
- m_araddr/m_arlen/m_arsize/m_arburst/m_arlock/m_arcache/m_arprot  out  as above  registered AR fields
- m_arvalid  out  1; m_arready  in  1
- m_rid  in  IDX_W+ID_W; m_rdata  in  DATA_W; m_rresp  in  2; m_rlast  in  1; m_rvalid  in  1
- m_rready  out  1  s_rready of the granted master while in R_DATA, else 0
- err_o  out  1  one-cycle pulse on a burst-length violation
- err_sticky_o  out  1  set by err_o; cleared only by rst

## Operation
- FSM states: IDLE, AR_ISSUE, R_DATA.
- IDLE: if any s_arvalid is high, the arbiter picks winner g and asserts s_arready[g] in the same cycle. The winner's AR fields are captured into m_ar* registers, g goes to the grant register, and the FSM enters AR_ISSUE.
  - ARB_MODE 0: highest asserted index wins.
  - ARB_MODE 1: the first asserted index at or after rr_ptr, searching upward and wrapping.
- AR_ISSUE: m_arvalid=1 and the fields are held stable. On m_arready, go to R_DATA and clear the beat counter.
- R_DATA: s_rvalid[g]=m_rvalid; m_rready=s_rready[g].
  - Each handshake increments the beat counter (4 bits, does not wrap for arlen up to 15).
  - A handshake with m_rlast returns the FSM to IDLE. In mode 1, rr_ptr becomes g+1 mod N.
- Length check: err_o pulses if m_rlast arrives on beat != arlen, or if the beat == arlen handshake lacks m_rlast. On a missing rlast the FSM still returns to IDLE after beat arlen.
- m_rid upper bits are ignored; the grant register is the routing authority.

## Timing
- Reset values: s_arready=0, s_rvalid=0, m_arvalid=0, m_rready=0, err_o=0, err_sticky_o=0, m_ar* fields=0, rr_ptr=0, FSM=IDLE.
- s_arready is combinational from s_arvalid in IDLE only; it is 0 in the other states.
- Latency: s_arvalid/s_arready handshake in cycle 0, m_arvalid in cycle 1. An R beat passes combinationally with 0 cycles.
- Minimum gap from one burst's last-beat handshake to the next s_arready is 1 cycle (the IDLE cycle).
- Simultaneous requests are resolved per ARB_MODE. Losers keep s_arvalid high and are served later; no request is dropped.
- Reset asserted mid-burst aborts immediately to IDLE. Downstream recovery is the system's responsibility.

## Structure
- Shared package holds the AXI3 field widths (LEN_W=4, SIZE_W=3, BURST_W=2, RESP_W=2), the FSM state enum, and the ARB_MODE constants.
- One natural sub-module is rr_arbiter: N-bit request vector plus pointer in, one-hot grant plus index out, with a fixed-priority mode.

## Test plan
- N=2, mode 1, both masters assert arvalid at cycle 0 -> master 0 granted; after its burst completes, master 1 is granted even though master 0 re-requests.
- N=2, mode 0, both assert arvalid repeatedly -> master 1 is always granted while it is requesting.
- Master 1 issues arid=3, arlen=3; m_arready is delayed 2 cycles -> m_arvalid is held with m_arid=5'b1_0011; 4 beats reach s_rvalid[1] only; s_rid[1]=3.
- s_rready[0] is deasserted for 3 cycles mid-burst -> m_rready=0 for those cycles, no beat is lost, and the beat count stays correct.
- arlen=1, but m_rlast is given on beat 0 -> err_o pulses once, err_sticky_o goes to 1, and the FSM returns to IDLE.
- rst is pulsed during R_DATA -> all outputs return to their reset values in the same cycle, and a new request is accepted after rst is released.

Source files
------------

// File: rtl/axi_read_arbiter_pkg.sv
// Shared definitions for the AXI3 read-channel arbiter: field widths,
// arbitration mode constants and the control FSM state type.
package axi_read_arbiter_pkg;

    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int LOCK_W  = 2;
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;
    localparam int RESP_W  = 2;

    localparam int ARB_FIXED = 0;   // highest requesting index wins
    localparam int ARB_RR    = 1;   // round-robin starting at rr_ptr

    typedef enum logic [1:0] {
        IDLE,
        AR_ISSUE,
        R_DATA
    } state_t;

endpackage

// File: rtl/axi_read_arbiter_rr_arbiter.sv
// Combinational N-way arbiter: request vector plus round-robin pointer in,
// one-hot grant plus binary index out. ARB_MODE selects fixed priority
// (highest index) or round-robin (first request at or after ptr, wrapping).
module axi_read_arbiter_rr_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int N        = 2,
    parameter int IDX_W    = 1,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    // Pick the winner; later loop iterations overwrite earlier ones, so the
    // last match in scan order is the one with the highest priority.
    always_comb begin
        int j;
        // NOTE: every output gets a default before any conditional write, so
        // no path leaves a value unassigned and no latch is inferred.
        j         = 0;
        grant_idx = '0;
        grant     = '0;
        valid     = |req;
        if (ARB_MODE == ARB_FIXED) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) grant_idx = IDX_W'(i);
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                j = (int'(ptr) + k) % N;
                if (req[j]) grant_idx = IDX_W'(j);
            end
        end
        if (valid) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// N-to-1 AXI3 read arbiter. One burst is in flight at a time: a request is
// accepted in IDLE, replayed on the master AR channel in AR_ISSUE, and its
// R beats are routed back to the granted master in R_DATA. The master index
// is prepended to ARID; the grant register, not RID, steers the R channel.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ARB_MODE  = ARB_RR,
    parameter int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic                           aclk,
    input  logic                           rst,
    input  logic [N_MASTERS*ID_W-1:0]      s_arid,
    input  logic [N_MASTERS*ADDR_W-1:0]    s_araddr,
    input  logic [N_MASTERS*LEN_W-1:0]     s_arlen,
    input  logic [N_MASTERS*SIZE_W-1:0]    s_arsize,
    input  logic [N_MASTERS*BURST_W-1:0]   s_arburst,
    input  logic [N_MASTERS*LOCK_W-1:0]    s_arlock,
    input  logic [N_MASTERS*CACHE_W-1:0]   s_arcache,
    input  logic [N_MASTERS*PROT_W-1:0]    s_arprot,
    input  logic [N_MASTERS-1:0]           s_arvalid,
    output logic [N_MASTERS-1:0]           s_arready,
    output logic [N_MASTERS*ID_W-1:0]      s_rid,
    output logic [N_MASTERS*DATA_W-1:0]    s_rdata,
    output logic [N_MASTERS*RESP_W-1:0]    s_rresp,
    output logic [N_MASTERS-1:0]           s_rlast,
    output logic [N_MASTERS-1:0]           s_rvalid,
    input  logic [N_MASTERS-1:0]           s_rready,
    output logic [IDX_W+ID_W-1:0]          m_arid,
    output logic [ADDR_W-1:0]              m_araddr,
    output logic [LEN_W-1:0]               m_arlen,
    output logic [SIZE_W-1:0]              m_arsize,
    output logic [BURST_W-1:0]             m_arburst,
    output logic [LOCK_W-1:0]              m_arlock,
    output logic [CACHE_W-1:0]             m_arcache,
    output logic [PROT_W-1:0]              m_arprot,
    output logic                           m_arvalid,
    input  logic                           m_arready,
    input  logic [IDX_W+ID_W-1:0]          m_rid,
    input  logic [DATA_W-1:0]              m_rdata,
    input  logic [RESP_W-1:0]              m_rresp,
    input  logic                           m_rlast,
    input  logic                           m_rvalid,
    output logic                           m_rready,
    output logic                           err_o,
    output logic                           err_sticky_o
);

    state_t               state, state_next;
    logic [IDX_W-1:0]     grant_q;
    logic [IDX_W-1:0]     rr_ptr;
    logic [ID_W-1:0]      arid_q;
    logic [LEN_W-1:0]     beat_cnt;
    logic [N_MASTERS-1:0] arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;
    logic                 ar_accept;
    logic                 r_hs;
    logic                 beat_is_len;
    logic                 unused_rid_hi;

    axi_read_arbiter_rr_arbiter #(
        .N        (N_MASTERS),
        .IDX_W    (IDX_W),
        .ARB_MODE (ARB_MODE)
    ) u_rr_arbiter (
        .req       (s_arvalid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    // A request is only taken in IDLE and never while reset is held, so no
    // handshake can be acknowledged and then lost to the reset.
    assign ar_accept   = (state == IDLE) && arb_valid && !rst;
    assign beat_is_len = (beat_cnt == m_arlen);
    assign m_arid      = {grant_q, arid_q};

    // R payload is broadcast; only s_rvalid is steered to the granted master.
    assign s_rid         = {N_MASTERS{m_rid[ID_W-1:0]}};
    assign s_rdata       = {N_MASTERS{m_rdata}};
    assign s_rresp       = {N_MASTERS{m_rresp}};
    assign s_rlast       = {N_MASTERS{m_rlast}};
    assign unused_rid_hi = ^m_rid[IDX_W+ID_W-1:ID_W];

    // Next-state and handshake outputs for the three-state burst FSM.
    always_comb begin
        state_next = state;
        s_arready  = '0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        s_rvalid   = '0;
        r_hs       = 1'b0;
        err_o      = 1'b0;
        case (state)
            IDLE: begin
                if (ar_accept) begin
                    s_arready  = arb_grant;
                    state_next = AR_ISSUE;
                end
            end
            AR_ISSUE: begin
                m_arvalid = 1'b1;
                if (m_arready) state_next = R_DATA;
            end
            R_DATA: begin
                s_rvalid[grant_q] = m_rvalid;
                m_rready          = s_rready[grant_q];
                r_hs              = m_rvalid && s_rready[grant_q];
                if (r_hs) begin
                    // rlast must coincide exactly with beat arlen
                    err_o = (m_rlast != beat_is_len);
                    if (m_rlast || beat_is_len) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge aclk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Capture the winner's AR fields and grant index on acceptance.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            grant_q   <= '0;
            arid_q    <= '0;
            m_araddr  <= '0;
            m_arlen   <= '0;
            m_arsize  <= '0;
            m_arburst <= '0;
            m_arlock  <= '0;
            m_arcache <= '0;
            m_arprot  <= '0;
        end else if (ar_accept) begin
            grant_q   <= arb_idx;
            arid_q    <= s_arid[int'(arb_idx)*ID_W +: ID_W];
            m_araddr  <= s_araddr[int'(arb_idx)*ADDR_W +: ADDR_W];
            m_arlen   <= s_arlen[int'(arb_idx)*LEN_W +: LEN_W];
            m_arsize  <= s_arsize[int'(arb_idx)*SIZE_W +: SIZE_W];
            m_arburst <= s_arburst[int'(arb_idx)*BURST_W +: BURST_W];
            m_arlock  <= s_arlock[int'(arb_idx)*LOCK_W +: LOCK_W];
            m_arcache <= s_arcache[int'(arb_idx)*CACHE_W +: CACHE_W];
            m_arprot  <= s_arprot[int'(arb_idx)*PROT_W +: PROT_W];
        end
    end

    // Beat counter: cleared when the AR is taken, bumped on every R handshake.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst)                                 beat_cnt <= '0;
        else if (state == AR_ISSUE && m_arready) beat_cnt <= '0;
        else if (r_hs)                           beat_cnt <= beat_cnt + 1'b1;
    end

    // Round-robin pointer moves past the master whose burst just ended.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (ARB_MODE == ARB_RR && r_hs && state_next == IDLE) begin
            rr_ptr <= (int'(grant_q) == N_MASTERS - 1) ? '0 : grant_q + 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst)        err_sticky_o <= 1'b0;
        else if (err_o) err_sticky_o <= 1'b1;
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: a round-robin instance driven by
// directed and randomized bursts against a request-level reference model,
// and a fixed-priority instance checked for highest-index-wins.
module tb_axi_read_arbiter;
    import axi_read_arbiter_pkg::*;

    localparam int NM     = 2;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 1;

    logic aclk = 1'b0;
    logic rst;
    always #5 aclk = ~aclk;

    // ---------------- round-robin instance ----------------
    logic [NM*ID_W-1:0]    s_arid;
    logic [NM*ADDR_W-1:0]  s_araddr;
    logic [NM*LEN_W-1:0]   s_arlen;
    logic [NM*SIZE_W-1:0]  s_arsize;
    logic [NM*BURST_W-1:0] s_arburst;
    logic [NM*LOCK_W-1:0]  s_arlock;
    logic [NM*CACHE_W-1:0] s_arcache;
    logic [NM*PROT_W-1:0]  s_arprot;
    logic [NM-1:0]         s_arvalid, s_arready;
    logic [NM*ID_W-1:0]    s_rid;
    logic [NM*DATA_W-1:0]  s_rdata;
    logic [NM*RESP_W-1:0]  s_rresp;
    logic [NM-1:0]         s_rlast, s_rvalid, s_rready;
    logic [IDX_W+ID_W-1:0] m_arid, m_rid;
    logic [ADDR_W-1:0]     m_araddr;
    logic [LEN_W-1:0]      m_arlen;
    logic [SIZE_W-1:0]     m_arsize;
    logic [BURST_W-1:0]    m_arburst;
    logic [LOCK_W-1:0]     m_arlock;
    logic [CACHE_W-1:0]    m_arcache;
    logic [PROT_W-1:0]     m_arprot;
    logic                  m_arvalid, m_arready;
    logic [DATA_W-1:0]     m_rdata;
    logic [RESP_W-1:0]     m_rresp;
    logic                  m_rlast, m_rvalid, m_rready;
    logic                  err_o, err_sticky_o;

    axi_read_arbiter #(
        .N_MASTERS(NM), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ARB_MODE(ARB_RR)
    ) dut (
        .aclk(aclk), .rst(rst),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .err_o(err_o), .err_sticky_o(err_sticky_o)
    );

    // ---------------- fixed-priority instance ----------------
    logic [NM*ID_W-1:0]    f_arid;
    logic [NM*ADDR_W-1:0]  f_araddr;
    logic [NM*LEN_W-1:0]   f_arlen;
    logic [NM*SIZE_W-1:0]  f_arsize;
    logic [NM*BURST_W-1:0] f_arburst;
    logic [NM*LOCK_W-1:0]  f_arlock;
    logic [NM*CACHE_W-1:0] f_arcache;
    logic [NM*PROT_W-1:0]  f_arprot;
    logic [NM-1:0]         f_arvalid, f_arready;
    logic [NM*ID_W-1:0]    f_rid;
    logic [NM*DATA_W-1:0]  f_rdata;
    logic [NM*RESP_W-1:0]  f_rresp;
    logic [NM-1:0]         f_rlast, f_rvalid, f_rready;
    logic [IDX_W+ID_W-1:0] f_m_arid;
    logic [ADDR_W-1:0]     f_m_araddr;
    logic [LEN_W-1:0]      f_m_arlen;
    logic [SIZE_W-1:0]     f_m_arsize;
    logic [BURST_W-1:0]    f_m_arburst;
    logic [LOCK_W-1:0]     f_m_arlock;
    logic [CACHE_W-1:0]    f_m_arcache;
    logic [PROT_W-1:0]     f_m_arprot;
    logic                  f_m_arvalid, f_m_arready;
    logic                  f_m_rlast, f_m_rvalid, f_m_rready;
    logic                  f_err, f_err_sticky;

    axi_read_arbiter #(
        .N_MASTERS(NM), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ARB_MODE(ARB_FIXED)
    ) dut_fx (
        .aclk(aclk), .rst(rst),
        .s_arid(f_arid), .s_araddr(f_araddr), .s_arlen(f_arlen), .s_arsize(f_arsize),
        .s_arburst(f_arburst), .s_arlock(f_arlock), .s_arcache(f_arcache), .s_arprot(f_arprot),
        .s_arvalid(f_arvalid), .s_arready(f_arready),
        .s_rid(f_rid), .s_rdata(f_rdata), .s_rresp(f_rresp), .s_rlast(f_rlast),
        .s_rvalid(f_rvalid), .s_rready(f_rready),
        .m_arid(f_m_arid), .m_araddr(f_m_araddr), .m_arlen(f_m_arlen), .m_arsize(f_m_arsize),
        .m_arburst(f_m_arburst), .m_arlock(f_m_arlock), .m_arcache(f_m_arcache), .m_arprot(f_m_arprot),
        .m_arvalid(f_m_arvalid), .m_arready(f_m_arready),
        .m_rid(5'h00), .m_rdata(32'h0), .m_rresp(2'b00), .m_rlast(f_m_rlast),
        .m_rvalid(f_m_rvalid), .m_rready(f_m_rready),
        .err_o(f_err), .err_sticky_o(f_err_sticky)
    );

    // ---------------- reference model state ----------------
    int errors = 0;
    int checks = 0;
    int rr_ptr_m;
    logic sticky_m;
    logic        req_v    [NM];
    logic [3:0]  req_id   [NM];
    logic [3:0]  req_len  [NM];
    logic [31:0] req_addr [NM];
    logic [2:0]  req_size [NM];

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Round-robin rule: first pending master at or after the pointer, wrapping.
    function automatic int pick_rr(input int ptr);
        for (int k = 0; k < NM; k++) begin
            if (req_v[(ptr + k) % NM]) return (ptr + k) % NM;
        end
        return -1;
    endfunction

    // Fixed rule: highest pending index.
    function automatic int pick_fixed(input logic [NM-1:0] req);
        for (int i = NM - 1; i >= 0; i--) begin
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic new_req(input int m, input logic [3:0] id, input logic [3:0] len);
        req_v[m]    = 1'b1;
        req_id[m]   = id;
        req_len[m]  = len;
        req_addr[m] = $urandom;
        req_size[m] = 3'($urandom_range(0, 2));
    endtask

    task automatic drive_req();
        for (int m = 0; m < NM; m++) begin
            s_arvalid[m]                 = req_v[m];
            s_arid[m*ID_W +: ID_W]       = req_id[m];
            s_araddr[m*ADDR_W +: ADDR_W] = req_addr[m];
            s_arlen[m*LEN_W +: LEN_W]    = req_len[m];
            s_arsize[m*SIZE_W +: SIZE_W] = req_size[m];
            s_arburst[m*BURST_W +: BURST_W] = 2'b01;
            s_arlock[m*LOCK_W +: LOCK_W]    = 2'b00;
            s_arcache[m*CACHE_W +: CACHE_W] = 4'(m + 3);
            s_arprot[m*PROT_W +: PROT_W]    = 3'(m + 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arready"}, s_arready, 0);
        check({tag, "_rvalid"}, s_rvalid, 0);
        check({tag, "_m_arvalid"}, m_arvalid, 0);
        check({tag, "_m_rready"}, m_rready, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_sticky"}, err_sticky_o, 0);
        check({tag, "_m_araddr"}, m_araddr, 0);
        check({tag, "_m_arid"}, m_arid, 0);
    endtask

    // One complete burst from the IDLE cycle: grant, AR replay held for
    // ar_delay cycles, R beats with an optional stall, rlast at last_beat.
    task automatic serve(input int ar_delay, input int stall_at, input int stall_len, input int last_beat);
        int g, len, beats;
        logic [31:0] d;
        logic exp_err;
        drive_req();
        #1;
        g = pick_rr(rr_ptr_m);
        check("ar_grant", s_arready, 64'(1 << g));
        @(posedge aclk); #1;
        req_v[g] = 1'b0;
        drive_req();
        len = int'(req_len[g]);
        for (int i = 0; i <= ar_delay; i++) begin
            m_arready = (i == ar_delay);
            #1;
            check("ar_valid", m_arvalid, 1);
            check("ar_id", m_arid, 64'((g << ID_W) | int'(req_id[g])));
            check("ar_addr", m_araddr, req_addr[g]);
            check("ar_len", m_arlen, req_len[g]);
            check("ar_size", m_arsize, req_size[g]);
            check("ar_prot", m_arprot, 64'(g + 1));
            check("ar_hold_ready", s_arready, 0);
            @(posedge aclk); #1;
        end
        m_arready = 1'b0;
        beats = ((last_beat < len) ? last_beat : len) + 1;
        exp_err = 1'b0;
        for (int b = 0; b < beats; b++) begin
            d        = $urandom;
            m_rvalid = 1'b1;
            m_rdata  = d;
            m_rresp  = 2'($urandom);
            m_rid    = {1'($urandom), req_id[g]};
            m_rlast  = (b == last_beat);
            if (b == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    s_rready = '1;
                    s_rready[g] = 1'b0;
                    #1;
                    check("stall_m_rready", m_rready, 0);
                    check("stall_s_rvalid", s_rvalid, 64'(1 << g));
                    @(posedge aclk); #1;
                end
            end
            s_rready = '1;
            #1;
            check("beat_s_rvalid", s_rvalid, 64'(1 << g));
            check("beat_m_rready", m_rready, 1);
            check("beat_rdata", s_rdata[g*DATA_W +: DATA_W], d);
            check("beat_rid", s_rid[g*ID_W +: ID_W], req_id[g]);
            check("beat_rlast", s_rlast, (b == last_beat) ? 64'(2**NM - 1) : 64'h0);
            check("beat_err", err_o, (b == beats - 1) && (last_beat != len));
            check("beat_arready", s_arready, 0);
            if ((b == beats - 1) && (last_beat != len)) exp_err = 1'b1;
            @(posedge aclk); #1;
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        if (exp_err) sticky_m = 1'b1;
        check("sticky", err_sticky_o, sticky_m);
        rr_ptr_m = (g + 1) % NM;
    endtask

    initial begin
        int g, n;
        rst = 1'b1;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0; m_rresp = '0; m_rid = '0;
        s_rready = '0;
        rr_ptr_m = 0; sticky_m = 1'b0;
        f_arid = {4'h9, 4'h6}; f_araddr = '0; f_arlen = '0; f_arsize = '0; f_arburst = '0;
        f_arlock = '0; f_arcache = '0; f_arprot = '0; f_arvalid = '0; f_rready = '0;
        f_m_arready = 1'b0; f_m_rvalid = 1'b0; f_m_rlast = 1'b0;

        // Reset with both masters already requesting: nothing may be accepted.
        new_req(0, 4'h1, 4'd2);
        new_req(1, 4'h2, 4'd1);
        drive_req();
        repeat (3) @(posedge aclk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;

        // Simultaneous requests: master 0 first, then master 1 despite master 0 re-requesting.
        serve(0, 99, 0, 2);
        new_req(0, 4'h4, 4'd0);
        serve(1, 99, 0, 1);
        serve(0, 99, 0, 0);

        // Master 1 id 3 len 3, AR held two cycles: m_arid = 5'b1_0011.
        new_req(1, 4'h3, 4'd3);
        serve(2, 99, 0, 3);

        // Master 0 back-pressures for three cycles mid-burst.
        new_req(0, 4'h7, 4'd5);
        serve(0, 2, 3, 5);

        // Early rlast on beat 0 of a two-beat burst, then a missing rlast.
        new_req(0, 4'h8, 4'd1);
        serve(0, 99, 0, 0);
        new_req(1, 4'h9, 4'd2);
        serve(0, 99, 0, 15);

        // Reset in the middle of an R burst.
        new_req(0, 4'hA, 4'd3);
        drive_req();
        @(posedge aclk); #1;
        req_v[0] = 1'b0;
        drive_req();
        m_arready = 1'b1;
        @(posedge aclk); #1;
        m_arready = 1'b0;
        m_rvalid = 1'b1; m_rdata = $urandom; s_rready = '1;
        #1;
        check("pre_rst_rvalid", s_rvalid, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge aclk); #1;
        rst = 1'b0;
        m_rvalid = 1'b0;
        rr_ptr_m = 0;
        sticky_m = 1'b0;
        new_req(1, 4'hB, 4'd1);
        serve(0, 99, 0, 1);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 25; t++) begin
            for (int m = 0; m < NM; m++) begin
                if (!req_v[m] && ($urandom_range(0, 1) == 1))
                    new_req(m, 4'($urandom), 4'($urandom_range(0, 7)));
            end
            if (!req_v[0] && !req_v[1])
                new_req($urandom_range(0, 1), 4'($urandom), 4'($urandom_range(0, 7)));
            n = 0;
            for (int m = 0; m < NM; m++) if (req_v[m]) n = int'(req_len[m]);
            serve($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 2),
                  ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : 99);
        end

        // Fixed priority: highest requesting index always wins.
        f_rready = '1;
        for (int t = 0; t < 10; t++) begin
            f_arvalid = {1'($urandom_range(0, 3) != 0), 1'b1};
            #1;
            g = pick_fixed(f_arvalid);
            check("fx_grant", f_arready, 64'(1 << g));
            @(posedge aclk); #1;
            f_arvalid = '0;
            f_m_arready = 1'b1;
            #1;
            check("fx_arid", f_m_arid, 64'((g << ID_W) | ((g == 1) ? 9 : 6)));
            @(posedge aclk); #1;
            f_m_arready = 1'b0;
            f_m_rvalid = 1'b1;
            f_m_rlast = 1'b1;
            #1;
            check("fx_rvalid", f_rvalid, 64'(1 << g));
            @(posedge aclk); #1;
            f_m_rvalid = 1'b0;
            f_m_rlast = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
